ex_mem_skid: RTL
================

Name: ex_mem_skid

Overview:
- Pipeline buffer between the EX stage and the MEM stage of the 5-stage MIPS core.
- Captures EX results (destination address, write-enable, write data) and presents them to MEM through a valid/ready handshake.
- Two-entry skid buffer, so a MEM stall never drops an in-flight EX result and EX ready is a registered signal.
- Synchronous flush discards all buffered results on exception or branch-mispredict redirect.

Parameters:
- DATA_W, 32, width of write-back data.
- ADDR_W, 5, width of destination register address.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- flush  in  1  synchronous discard of all buffered entries.
- ex_valid  in  1  EX presents a result this cycle.
- ex_ready  out  1  buffer can accept a result this cycle.
- ex_wd  in  ADDR_W  destination register address from EX.
- ex_wreg  in  1  write-enable from EX.
- ex_wdata  in  DATA_W  write data from EX.
- mem_valid  out  1  oldest entry presented to MEM.
- mem_ready  in  1  MEM consumes the presented entry.
- mem_wd  out  ADDR_W  address of oldest entry.
- mem_wreg  out  1  write-enable of oldest entry.
- mem_wdata  out  DATA_W  data of oldest entry.
- occupancy  out  2  number of valid entries, 0..2.

Behaviour:
- Storage:
  - main register holds the oldest entry and drives the mem_* outputs.
  - skid register holds the second entry.
- Handshakes:
  - accept = ex_valid & ex_ready.
  - pop = mem_valid & mem_ready.
- State machine with states EMPTY, ONE, FULL:
  - EMPTY: accept -> ONE, main <= ex_*; otherwise stay.
  - ONE, accept & pop -> ONE, main <= ex_*.
  - ONE, accept & !pop -> FULL, skid <= ex_*.
  - ONE, !accept & pop -> EMPTY.
  - ONE, neither -> stay.
  - FULL: pop -> ONE, main <= skid. EX cannot accept in FULL because ex_ready=0.
  - FULL, no pop -> stay, all registers hold.
- Outputs decoded from registered state:
  - ex_ready = (state != FULL).
  - mem_valid = (state != EMPTY).
  - occupancy = 0, 1 or 2 for EMPTY, ONE, FULL.
- Latency: a result accepted in cycle N appears on mem_* in cycle N+1 when the buffer was EMPTY, or when it was ONE with a pop in cycle N.
- Ordering is strict FIFO; no reordering, no merging.
- Entries with ex_wreg=0 are stored and forwarded like any other entry (the MEM stage may still need them for stores and loads).
- mem_wd, mem_wreg and mem_wdata are held stable while mem_valid=1 and mem_ready=0.
- mem_* outputs read 0 whenever state=EMPTY: main is cleared on the transition to EMPTY.
- Reset:
  - rst=1 -> next state EMPTY; main, skid and all mem_* outputs cleared to 0; occupancy=0.
  - After reset, ex_ready=1 and mem_valid=0.
  - rst has priority over flush and over all handshakes.
  - Any accept or pop occurring in a cycle with rst=1 is discarded.
- Flush:
  - flush=1 (rst=0) -> same next-state as reset.
  - A simultaneous accept is dropped.
  - A simultaneous pop is still considered consumed by MEM; the buffer does not re-present it.
- Reset or flush mid-stall (FULL with mem_ready=0) empties both entries in one cycle.

Optional Feature:
- Macro EX_MEM_FWD_EN.
- When defined, three extra outputs are added:
  - fwd_valid (1): entry exists and its wreg=1.
  - fwd_wd (ADDR_W)
  - fwd_wdata (DATA_W)
- These present the youngest buffered entry with wreg=1 (skid if valid with wreg=1, else main if valid with wreg=1) so the ID stage can forward from EX/MEM.
- fwd_* are combinational from the registers and read 0 when fwd_valid=0 or after reset/flush.
- When not defined, the ports do not exist and no forwarding logic is generated.

Test Plan:
- Reset then stream: rst high 2 cycles, then ex_valid=1 with wd=3, wreg=1, wdata=0x0000_00FF and mem_ready=1 -> next cycle mem_valid=1, mem_wd=3, mem_wdata=0xFF, occupancy=1, ex_ready=1.
- Back-pressure: mem_ready=0, accept A (0x11) then B (0x22) -> occupancy=2, ex_ready=0, mem_wdata stays 0x11. Then raise mem_ready -> 0x11 then 0x22 delivered in consecutive cycles, ex_ready returns to 1 after the first pop.
- Full, ex_valid held: in FULL with ex_valid=1 for 5 cycles and mem_ready=0 -> no state change, no data overwrite, mem_wdata constant.
- Flush while FULL: flush=1 with ex_valid=1 (0x33) -> next cycle occupancy=0, mem_valid=0, mem_* = 0, ex_ready=1, and 0x33 is never presented.
- Simultaneous accept/pop in ONE: continuous ex_valid=1 and mem_ready=1 over data 1..8 -> occupancy stays 1, outputs 1..8 in order with no bubbles.
- EX_MEM_FWD_EN build: main has wd=4, wreg=1, data 0xA; skid has wd=4, wreg=1, data 0xB -> fwd_wd=4, fwd_wdata=0xB. After a pop, fwd_wdata=0xB from main; after flush, fwd_valid=0.

Source files
------------

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry EX/MEM skid buffer with valid/ready handshake and flush.
// Optional EX_MEM_FWD_EN adds fwd_* outputs exposing the youngest buffered write.
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_wd,
  input  logic              ex_wreg,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_wd,
  output logic              mem_wreg,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        occupancy
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_wd,
  output logic [DATA_W-1:0] fwd_wdata
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] main_wd, skid_wd;
  logic              main_wreg, skid_wreg;
  logic [DATA_W-1:0] main_wdata, skid_wdata;
  logic accept, pop, ld_main_ex, ld_main_skid, ld_skid, clr_main;
  assign ex_ready  = state != FULL;
  assign mem_valid = state != EMPTY;
  assign occupancy = state;
  assign accept    = ex_valid & ex_ready;
  assign pop       = mem_valid & mem_ready;
  assign mem_wd    = main_wd;
  assign mem_wreg  = main_wreg;
  assign mem_wdata = main_wdata;
  always_comb begin
    state_n      = state;
    ld_main_ex   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    clr_main     = 1'b0;
    case (state)
      EMPTY: begin
        state_n    = accept ? ONE : EMPTY;
        ld_main_ex = accept;
      end
      ONE: begin
        state_n    = accept ? (pop ? ONE : FULL) : (pop ? EMPTY : ONE);
        ld_main_ex = accept & pop;
        ld_skid    = accept & ~pop;
        clr_main   = ~accept & pop;
      end
      FULL: begin
        state_n      = pop ? ONE : FULL;
        ld_main_skid = pop;
      end
      default: state_n = EMPTY;
    endcase
  end
  // rst and flush share one path and override every handshake in that cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= EMPTY;
      main_wd    <= '0;
      main_wreg  <= 1'b0;
      main_wdata <= '0;
      skid_wd    <= '0;
      skid_wreg  <= 1'b0;
      skid_wdata <= '0;
    end else begin
      state <= state_n;
      if (ld_main_ex) begin
        main_wd    <= ex_wd;
        main_wreg  <= ex_wreg;
        main_wdata <= ex_wdata;
      end else if (ld_main_skid) begin
        main_wd    <= skid_wd;
        main_wreg  <= skid_wreg;
        main_wdata <= skid_wdata;
      end else if (clr_main) begin
        main_wd    <= '0;
        main_wreg  <= 1'b0;
        main_wdata <= '0;
      end
      if (ld_skid) begin
        skid_wd    <= ex_wd;
        skid_wreg  <= ex_wreg;
        skid_wdata <= ex_wdata;
      end
    end
  end
`ifdef EX_MEM_FWD_EN
  logic skid_hit, main_hit;
  assign skid_hit  = (state == FULL) & skid_wreg;
  assign main_hit  = (state != EMPTY) & main_wreg;
  assign fwd_valid = skid_hit | main_hit;
  assign fwd_wd    = skid_hit ? skid_wd : main_hit ? main_wd : '0;
  assign fwd_wdata = skid_hit ? skid_wdata : main_hit ? main_wdata : '0;
`endif
endmodule
